// File: rtl/cardinal_input_buffer.sv
// Router input port with two virtual-channel buffers. Each VC holds one packet, and the
// VC in use alternates with the router polarity. Optional counters: CARDINAL_IBUF_STATS_EN.
module cardinal_input_buffer #(
    parameter int DATA_W  = 64,
    parameter int HOP_LSB = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              si,
    input  logic [DATA_W-1:0] di,
    output logic              ri,
    output logic              out_valid,
    output logic [2:0]        out_req,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_gnt,
    output logic              err_vc
`ifdef CARDINAL_IBUF_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [7:0]        drop_cnt
`endif
);

    localparam logic [2:0] REQ_CW  = 3'b001;
    localparam logic [2:0] REQ_CCW = 3'b010;
    localparam logic [2:0] REQ_PE  = 3'b100;

    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic              full0;
    logic              full1;

    logic              ext_full;
    logic              int_full;
    logic [DATA_W-1:0] int_buf;
    logic [7:0]        int_hop;
    logic              vc_match;
    logic              handshake;
    logic              accept;
    logic              drop;
    logic              release_int;

    function automatic logic [7:0] hop_dec(input logic [7:0] h);
        return (h == 8'd0) ? 8'd0 : h - 8'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    // External VC follows polarity; the internal (switch-facing) VC is the other one.
    assign ext_full = polarity ? full1 : full0;
    assign int_full = polarity ? full0 : full1;
    assign int_buf  = polarity ? buf0  : buf1;
    assign int_hop  = int_buf[HOP_LSB +: 8];

    assign ri          = ~reset & ~ext_full;
    assign vc_match    = (di[DATA_W-1] == polarity);
    assign handshake   = si & ri;
    assign accept      = handshake & vc_match;
    assign drop        = handshake & ~vc_match;
    assign release_int = int_full & out_gnt;

    assign out_valid = int_full;

    always_comb begin
        out_data                 = int_buf;
        out_data[HOP_LSB +: 8]   = hop_dec(int_hop);
    end

    always_comb begin
        out_req = 3'b000;
        if (int_full) begin
            if (int_hop == 8'd0)
                out_req = REQ_PE;
            else if (int_buf[DATA_W-2])
                out_req = REQ_CCW;
            else
                out_req = REQ_CW;
        end
    end

    // Accept and release never hit the same VC in one cycle, so each buffer has one writer per phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf0   <= '0;
            buf1   <= '0;
            full0  <= 1'b0;
            full1  <= 1'b0;
            err_vc <= 1'b0;
        end else begin
            if (accept && !polarity) begin
                buf0  <= di;
                full0 <= 1'b1;
            end else if (release_int && polarity) begin
                full0 <= 1'b0;
            end

            if (accept && polarity) begin
                buf1  <= di;
                full1 <= 1'b1;
            end else if (release_int && !polarity) begin
                full1 <= 1'b0;
            end

            if (drop)
                err_vc <= 1'b1;
        end
    end

`ifdef CARDINAL_IBUF_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt  <= 16'd0;
            drop_cnt <= 8'd0;
        end else begin
            if (accept)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (drop)
                drop_cnt <= sat_inc8(drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_cardinal_input_buffer.sv
// Directed bench for cardinal_input_buffer: reset, forwarding, local delivery,
// backpressure, VC mismatch and asynchronous mid-operation reset.
module tb_cardinal_input_buffer;

    localparam int DATA_W  = 64;
    localparam int HOP_LSB = 48;

    logic              clk;
    logic              reset;
    logic              polarity;
    logic              si;
    logic [DATA_W-1:0] di;
    logic              ri;
    logic              out_valid;
    logic [2:0]        out_req;
    logic [DATA_W-1:0] out_data;
    logic              out_gnt;
    logic              err_vc;
`ifdef CARDINAL_IBUF_STATS_EN
    logic [15:0]       pkt_cnt;
    logic [7:0]        drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cardinal_input_buffer #(.DATA_W(DATA_W), .HOP_LSB(HOP_LSB)) dut (
        .clk       (clk),
        .reset     (reset),
        .polarity  (polarity),
        .si        (si),
        .di        (di),
        .ri        (ri),
        .out_valid (out_valid),
        .out_req   (out_req),
        .out_data  (out_data),
        .out_gnt   (out_gnt),
        .err_vc    (err_vc)
`ifdef CARDINAL_IBUF_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock: inputs are released after the edge and polarity flips.
    task automatic step();
        @(posedge clk);
        #1;
        polarity = ~polarity;
        si       = 1'b0;
        out_gnt  = 1'b0;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        polarity = 1'b0;
        si       = 1'b0;
        di       = '0;
        out_gnt  = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("rst_ri",        {63'd0, ri},        64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_req",   {61'd0, out_req},   64'd0);
        check("rst_err_vc",    {63'd0, err_vc},    64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ri", {63'd0, ri}, 64'd1);

        // Basic forward on VC0, cw, hop 1
        si = 1'b1;
        di = 64'h0001_0000_0000_0005;
        step();
        check("fwd_valid", {63'd0, out_valid}, 64'd1);
        check("fwd_req",   {61'd0, out_req},   64'd1);
        check("fwd_data",  out_data,           64'h0000_0000_0000_0005);
        check("fwd_ri_vc1", {63'd0, ri},       64'd1);
        out_gnt = 1'b1;
        step();
        check("fwd_gnt_ri",    {63'd0, ri},        64'd1);
        check("fwd_gnt_valid", {63'd0, out_valid}, 64'd0);

        // Local delivery on VC1, hop 0
        step();
        si = 1'b1;
        di = 64'h8000_0000_0000_00AA;
        step();
        check("loc_valid", {63'd0, out_valid}, 64'd1);
        check("loc_req",   {61'd0, out_req},   64'd4);
        check("loc_data",  out_data,           64'h8000_0000_0000_00AA);
        out_gnt = 1'b1;
        step();
        check("loc_rel_valid", {63'd0, out_valid}, 64'd0);
        check("loc_rel_ri",    {63'd0, ri},        64'd1);

        // Backpressure on VC0
        step();
        si = 1'b1;
        di = 64'h0002_0000_0000_0011;
        step();
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_req",   {61'd0, out_req},   64'd1);
        check("bp_data",  out_data,           64'h0001_0000_0000_0011);
        step();
        check("bp_ri_blocked", {63'd0, ri}, 64'd0);
        si = 1'b1;
        di = 64'h4003_0000_0000_0022;
        step();
        check("bp_data_kept", out_data,          64'h0001_0000_0000_0011);
        check("bp_req_kept",  {61'd0, out_req},  64'd1);
        check("bp_no_err",    {63'd0, err_vc},   64'd0);
        out_gnt = 1'b1;
        step();
        check("bp_ri_free", {63'd0, ri}, 64'd1);

        // VC mismatch on polarity 0
        si = 1'b1;
        di = 64'hC000_0000_0000_0003;
        step();
        check("mm_valid", {63'd0, out_valid}, 64'd0);
        check("mm_err",   {63'd0, err_vc},    64'd1);
`ifdef CARDINAL_IBUF_STATS_EN
        check("mm_drop_cnt", {56'd0, drop_cnt}, 64'd1);
`endif
        step();
        step();
        check("mm_err_sticky", {63'd0, err_vc}, 64'd1);

        // Fill both VCs: VC1 ccw hop 3, then VC0 cw hop 5
        si = 1'b1;
        di = 64'hC003_0000_0000_0033;
        step();
        check("ccw_valid", {63'd0, out_valid}, 64'd1);
        check("ccw_req",   {61'd0, out_req},   64'd2);
        check("ccw_data",  out_data,           64'hC002_0000_0000_0033);
        si = 1'b1;
        di = 64'h0005_0000_0000_0044;
        step();
        check("both_valid", {63'd0, out_valid}, 64'd1);
        check("both_data",  out_data,           64'h0004_0000_0000_0044);
        check("both_ri",    {63'd0, ri},        64'd0);
`ifdef CARDINAL_IBUF_STATS_EN
        check("pkt_cnt_5", {48'd0, pkt_cnt}, 64'd5);
`endif

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        check("ares_valid", {63'd0, out_valid}, 64'd0);
        check("ares_err",   {63'd0, err_vc},    64'd0);
        check("ares_ri",    {63'd0, ri},        64'd0);
        check("ares_req",   {61'd0, out_req},   64'd0);
`ifdef CARDINAL_IBUF_STATS_EN
        check("ares_pkt_cnt",  {48'd0, pkt_cnt},  64'd0);
        check("ares_drop_cnt", {56'd0, drop_cnt}, 64'd0);
`endif
        reset = 1'b0;
        step();
        check("post_ares_ri",    {63'd0, ri},        64'd1);
        check("post_ares_valid", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
